// File: rtl/fifo_pkg.sv
// Shared definitions for the asynchronous FIFO: default widths, Gray-code
// helpers and the read-side output register state type.
package fifo_pkg;

  localparam int FIFO_ADDR_WIDTH = 6;
  localparam int FIFO_DATA_WIDTH = 8;

  typedef enum logic {
    EMPTY_OUT = 1'b0,
    VALID     = 1'b1
  } out_state_t;

  // Helpers work on a 32-bit container so any pointer width up to 32 fits;
  // zero-extended upper bits stay zero in both directions.
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Width-parameterized two-flop synchronizer with async active-low reset.
// Used for both the write->read and read->write Gray pointer crossings.
module sync_2ff #(
  parameter int WIDTH = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/fifo_read_ctrl.sv
// Read-domain controller of the async FIFO: pointer sync, empty/almost-empty
// status, and a first-word-fall-through output register.
//
//   state     | meaning
//   EMPTY_OUT | dout holds no unconsumed word
//   VALID     | dout holds a word waiting for dout_ready
module fifo_read_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH    = FIFO_ADDR_WIDTH,
  parameter int DATA_WIDTH    = FIFO_DATA_WIDTH,
  parameter int AEMPTY_THRESH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH:0]   wptr,
  output logic [ADDR_WIDTH:0]   rptr,
  output logic [ADDR_WIDTH-1:0] raddr,
  input  logic [DATA_WIDTH-1:0] rdata_mem,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic                  empty,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   rd_count
);

  localparam int PW = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] AE_TH = PW'(AEMPTY_THRESH);

  logic [PW-1:0]         rq2_wptr;
  logic [PW-1:0]         rbin;
  logic [PW-1:0]         rbin_next;
  logic [PW-1:0]         rgray_next;
  logic [PW-1:0]         wbin_sync;
  logic [PW-1:0]         count_next;
  logic [31:0]           gray_full;
  logic [31:0]           wbin_full;
  logic                  unused_ptr_hi;
  logic                  consume;
  logic                  fetch;
  logic [DATA_WIDTH-1:0] dout_next;
  out_state_t            state;
  out_state_t            state_next;

  sync_2ff #(.WIDTH(PW)) u_wptr_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (wptr),
    .q     (rq2_wptr)
  );

  assign dout_valid    = (state == VALID);
  assign raddr         = rbin[ADDR_WIDTH-1:0];
  assign unused_ptr_hi = ^{gray_full[31:PW], wbin_full[31:PW]};

  always_comb begin
    consume    = dout_valid & dout_ready;
    fetch      = !empty & (!dout_valid | consume);
    rbin_next  = rbin + PW'(fetch);
    gray_full  = bin2gray(32'(rbin_next));
    rgray_next = gray_full[PW-1:0];
    wbin_full  = gray2bin(32'(rq2_wptr));
    wbin_sync  = wbin_full[PW-1:0];
    count_next = wbin_sync - rbin_next;
  end

  always_comb begin
    state_next = state;
    dout_next  = dout;
    case (state)
      EMPTY_OUT: begin
        if (fetch) begin
          dout_next  = rdata_mem;
          state_next = VALID;
        end
      end
      VALID: begin
        if (consume) begin
          if (fetch) begin
            dout_next = rdata_mem;
          end else begin
            state_next = EMPTY_OUT;
          end
        end
      end
      default: state_next = EMPTY_OUT;
    endcase
  end

  // empty compares against the synchronized pointer, so it can only lag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rbin         <= '0;
      rptr         <= '0;
      empty        <= 1'b1;
      almost_empty <= 1'b1;
      rd_count     <= '0;
      state        <= EMPTY_OUT;
      dout         <= '0;
    end else begin
      rbin         <= rbin_next;
      rptr         <= rgray_next;
      empty        <= (rgray_next == rq2_wptr);
      rd_count     <= count_next;
      almost_empty <= (count_next <= AE_TH);
      state        <= state_next;
      dout         <= dout_next;
    end
  end

endmodule

// File: doc/fifo_read_ctrl.md
# fifo_read_ctrl

Read-domain controller of the asynchronous FIFO. Synchronizes the write domain's Gray-coded write pointer into the read clock, maintains the binary/Gray read pointer, and generates empty and almost-empty status. Prefetches memory data into a first-word-fall-through output register with a valid/ready handshake. Sits between the dual-port memory's asynchronous read port and the read-side consumer; its `rptr` output feeds the write-side synchronizer.

## Interface

Parameters:
- `ADDR_WIDTH`, 6: memory address bits; depth = 2^ADDR_WIDTH (64).
- `DATA_WIDTH`, 8: word width.
- `AEMPTY_THRESH`, 4: `almost_empty` asserts when `rd_count` <= this value.

Ports:
- `clk`, in, 1: read-domain clock.
- `rst_n`, in, 1: reset; asynchronous, active-low.
- `wptr`, in, ADDR_WIDTH+1: Gray write pointer, write-clock domain.
- `rptr`, out, ADDR_WIDTH+1: registered Gray read pointer, to the write domain.
- `raddr`, out, ADDR_WIDTH: memory read address, equal to `rbin[ADDR_WIDTH-1:0]`.
- `rdata_mem`, in, DATA_WIDTH: memory data; combinational read of `raddr`.
- `dout`, out, DATA_WIDTH: output data register.
- `dout_valid`, out, 1: `dout` holds an unconsumed word.
- `dout_ready`, in, 1: consumer accepts `dout` this cycle.
- `empty`, out, 1: registered; no memory words remain beyond the output register.
- `almost_empty`, out, 1: registered; asserted when `rd_count` <= `AEMPTY_THRESH`.
- `rd_count`, out, ADDR_WIDTH+1: registered memory occupancy seen by the read side. Excludes the word held in `dout`.

## Operation

- Synchronizer: `wptr` passes through two flops to produce `rq2_wptr`. No logic is placed between the two flops.
- `consume = dout_valid & dout_ready`.
- `fetch = !empty & (!dout_valid | consume)`.
- `rbin_next = rbin + fetch`, computed modulo 2^(ADDR_WIDTH+1). `rgray_next = (rbin_next>>1) ^ rbin_next`.
- Each edge: `rbin <= rbin_next`, `rptr <= rgray_next`, `empty <= (rgray_next == rq2_wptr)`.
- Each edge: `rd_count <= gray2bin(rq2_wptr) - rbin_next`, computed modulo 2^(ADDR_WIDTH+1). `almost_empty <= (that value <= AEMPTY_THRESH)`.
- Output register, two states:
  - EMPTY_OUT (`dout_valid`=0): on `fetch`, `dout <= rdata_mem` and the state moves to VALID.
  - VALID (`dout_valid`=1):
    - `consume` with `fetch`: `dout` is replaced and the state stays VALID.
    - `consume` without `fetch`: the state moves to EMPTY_OUT; `dout` keeps its last value.
    - No `consume`: `dout` is held stable.
- `fetch` never occurs while `empty`=1. Underflow is structurally impossible.
- `dout_ready` is ignored while `dout_valid`=0.
- Wrap-around: `rbin` wraps from 2^(ADDR_WIDTH+1)-1 to 0. The `rptr` MSB toggles each time `raddr` wraps.
- Reset values: `rptr`=0, `rbin`=0, `raddr`=0, both sync flops=0, `empty`=1, `almost_empty`=1, `rd_count`=0, `dout_valid`=0, `dout`=0.
- Reset mid-operation clears all state asynchronously and discards any word in `dout`. The write domain must be reset in the same event.

## Timing

- Reference point: `wptr` changes and is stable before rclk edge k.
  - Sync flop 1 captures it at edge k.
  - `rq2_wptr` updates at edge k+1.
  - `empty` falls at edge k+2.
  - `dout_valid` rises at edge k+3, with `dout` = word at the old `raddr`.
- First-word latency is therefore 4 rclk edges after the write pointer update.
- Sustained throughput: one word per rclk while `dout_ready`=1 and the FIFO is non-empty.
- `empty` is pessimistic. It may stay asserted for up to 2 edges after data exists, and it never deasserts early.
- `rptr`, `empty`, `rd_count` and `almost_empty` all change only on clk edges and are glitch-free.

## Structure

- Package `fifo_pkg` holds:
  - the `ADDR_WIDTH`/`DATA_WIDTH` defaults;
  - the `bin2gray` and `gray2bin` functions;
  - the enum `out_state_t` = {EMPTY_OUT, VALID}.
- Sub-module `sync_2ff`: width-parameterized two-flop synchronizer with async active-low reset. It is shared with the write side's `rptr` synchronization.

## Test plan

- **Reset:** assert `rst_n`=0 mid-stream with `dout_valid`=1 → all outputs go to their reset values immediately, before any clk edge. After release, `empty`=1 and `dout_valid`=0.
- **First word:** memory[0]=8'hA5, `wptr` 0→1 before edge k → `empty`=0 at k+2; at k+3 `dout_valid`=1, `dout`=8'hA5, `raddr`=1, `rptr`=7'b0000001.
- **Backpressure:** 3 words (11, 22, 33), `dout_ready`=0 → `dout`=11 held and `rptr`=1 for 10 cycles. Then `dout_ready`=1 → 22 and 33 on consecutive cycles; `dout_valid`=0 one cycle after 33 is consumed; `empty`=1.
- **Wrap:** stream 130 words at `ADDR_WIDTH`=6 → `raddr` wraps 63→0 twice over the pass. `rbin` 127→0 produces `rptr` 7'b1000000→7'b0000000. Data order is preserved and no word is lost or repeated.
- **Almost-empty:** `rd_count`=5 with `AEMPTY_THRESH`=4 → `almost_empty`=0. One fetch → `rd_count`=4 and `almost_empty`=1 on the same edge.
- **Simultaneous:** `consume` and `fetch` in one cycle with 2 words in memory → `dout_valid` stays 1, `dout` updates to the next word, and `rd_count` decrements by 1.
